cpu_clken_gen: RTL and testbench

- Parametrised CPU clock-enable generator, successor to the BUFGCTRL-mux CPU clock.
- Runs entirely in the clk_28 domain and produces single-cycle rise and fall enables for the CPU core at NUM_SPEEDS binary-divided rates (default 3.5/7/14/28 MHz).
- Provides per-speed contention stretching, external wait, glitch-free speed switching at aligned boundaries, and a stall counter for debug registers.
- Sits between the machine-control registers (speed request) and the Z80 core and ULA contention logic.

---
 rtl/cpu_clken_gen.sv | 114 +++++++++++
 tb/tb_cpu_clken_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clken_gen.sv
// CPU clock-enable generator running entirely in the clk_28 domain.
// Issues single-cycle rise/fall enables at binary-divided rates, stretches
// the low phase on contention or external wait, switches speed only at the
// prescaler wrap and keeps a saturating count of suppressed rise slots.
module cpu_clken_gen #(
    parameter int unsigned NUM_SPEEDS   = 4,
    parameter int unsigned SPEED_BITS   = 2,
    parameter logic [7:0]  CONTEND_MASK = 8'b0000_0001,
    parameter int unsigned STALL_WIDTH  = 16
) (
    input  logic                   clk_28,
    input  logic                   reset_n,
    input  logic [SPEED_BITS-1:0]  cpu_speed,
    input  logic                   cpu_contend,
    input  logic                   cpu_wait_n,
    input  logic                   stall_clr,
    output logic                   cpu_clk_en,
    output logic                   cpu_clk_en_n,
    output logic                   cpu_clk_lsb,
    output logic [SPEED_BITS-1:0]  speed_active,
    output logic                   speed_pending,
    output logic [STALL_WIDTH-1:0] stall_count
);

    localparam int unsigned         PW        = NUM_SPEEDS - 1;
    localparam logic [SPEED_BITS-1:0] MAX_SPEED = SPEED_BITS'(NUM_SPEEDS - 1);

    typedef enum logic {RUN, PEND} state_t;

    state_t                state, state_next;
    logic [PW-1:0]         p;
    logic                  hold;
    logic [SPEED_BITS-1:0] speed_req, speed_next;
    logic [PW-1:0]         slot_mask, half_mask;
    int unsigned           lvl;
    logic                  p_wrap, rise_slot, fall_slot, suppress, issue, hold_next;

    assign speed_pending = (state == PEND);

    // Clamp the request and decode rise/fall slots for the speed in effect.
    always_comb begin
        speed_req = (cpu_speed > MAX_SPEED) ? MAX_SPEED : cpu_speed;
        lvl       = PW - 32'(speed_active);
        slot_mask = PW'((32'd1 << lvl) - 32'd1);
        // Top bit of the slot mask marks the half-period (fall) phase.
        half_mask = slot_mask ^ (slot_mask >> 1);
        p_wrap    = (p == '1);
        rise_slot = ((p & slot_mask) == '0);
        fall_slot = (slot_mask == '0) ? 1'b1 : ((p & slot_mask) == half_mask);
        suppress  = rise_slot & (~cpu_wait_n | (cpu_contend & CONTEND_MASK[speed_active]));
        issue     = rise_slot & ~suppress;
        hold_next = suppress | (hold & ~issue);
    end

    // Speed switch: latch a differing request, apply it only at the prescaler wrap.
    always_comb begin
        state_next = state;
        speed_next = speed_active;
        case (state)
            RUN: begin
                if (speed_req != speed_active) state_next = PEND;
            end
            PEND: begin
                if (p_wrap) begin
                    speed_next = speed_req;
                    state_next = RUN;
                end else if (speed_req == speed_active) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Free-running prescaler plus speed FSM state.
    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            p            <= '0;
            state        <= RUN;
            speed_active <= '0;
        end else begin
            p            <= p + 1'b1;
            state        <= state_next;
            speed_active <= speed_next;
        end
    end

    // Registered enables, hold flag and T-state parity.
    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            hold         <= 1'b0;
            cpu_clk_en   <= 1'b0;
            cpu_clk_en_n <= 1'b0;
            cpu_clk_lsb  <= 1'b0;
        end else begin
            hold         <= hold_next;
            cpu_clk_en   <= issue;
            cpu_clk_en_n <= fall_slot & ~hold_next;
            cpu_clk_lsb  <= cpu_clk_lsb ^ issue;
        end
    end

    // Saturating count of suppressed rise slots; clear wins over increment.
    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_clr) begin
            stall_count <= '0;
        end else if (suppress && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_clken_gen.sv
// Bench for cpu_clken_gen: a default instance and a 3-speed, 2-bit-counter
// instance share the same stimulus and are compared every cycle against a
// period/phase arithmetic model.
module tb_cpu_clken_gen;

    logic        clk_28 = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  cpu_speed = '0;
    logic        cpu_contend = 1'b0;
    logic        cpu_wait_n = 1'b1;
    logic        stall_clr = 1'b0;

    logic        a_en, a_en_n, a_lsb, a_pend;
    logic [1:0]  a_spd;
    logic [15:0] a_stall;
    logic        b_en, b_en_n, b_lsb, b_pend;
    logic [1:0]  b_spd;
    logic [1:0]  b_stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int n;
        int mask;
        int smax;
        int pc;
        int spd;
        bit pend;
        bit hold;
        bit en;
        bit en_n;
        bit lsb;
        int stall;
    } mdl_t;

    mdl_t m[2];

    cpu_clken_gen dut_a (
        .clk_28(clk_28), .reset_n(reset_n), .cpu_speed(cpu_speed),
        .cpu_contend(cpu_contend), .cpu_wait_n(cpu_wait_n), .stall_clr(stall_clr),
        .cpu_clk_en(a_en), .cpu_clk_en_n(a_en_n), .cpu_clk_lsb(a_lsb),
        .speed_active(a_spd), .speed_pending(a_pend), .stall_count(a_stall)
    );

    cpu_clken_gen #(
        .NUM_SPEEDS(3), .SPEED_BITS(2), .CONTEND_MASK(8'b0000_0011), .STALL_WIDTH(2)
    ) dut_b (
        .clk_28(clk_28), .reset_n(reset_n), .cpu_speed(cpu_speed),
        .cpu_contend(cpu_contend), .cpu_wait_n(cpu_wait_n), .stall_clr(stall_clr),
        .cpu_clk_en(b_en), .cpu_clk_en_n(b_en_n), .cpu_clk_lsb(b_lsb),
        .speed_active(b_spd), .speed_pending(b_pend), .stall_count(b_stall)
    );

    always #5 clk_28 = ~clk_28;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].pc = 0; m[k].spd = 0; m[k].pend = 0; m[k].hold = 0;
            m[k].en = 0; m[k].en_n = 0; m[k].lsb = 0; m[k].stall = 0;
        end
    endtask

    // Advance model k by one clk_28 cycle using the inputs now applied.
    task automatic model_step(input int k);
        int req, per, ph;
        bit rise, fall, sup, issue, wrap;
        req  = (int'(cpu_speed) >= m[k].n) ? m[k].n - 1 : int'(cpu_speed);
        per  = 1 << (m[k].n - 1 - m[k].spd);
        ph   = m[k].pc % per;
        rise = (ph == 0);
        fall = (per == 1) || (ph == per / 2);
        sup  = rise && (!cpu_wait_n || (cpu_contend && (((m[k].mask >> m[k].spd) & 1) == 1)));
        issue = rise && !sup;
        wrap = (m[k].pc == (1 << (m[k].n - 1)) - 1);
        if (sup) m[k].hold = 1;
        else if (issue) m[k].hold = 0;
        m[k].en   = issue;
        m[k].en_n = fall && !m[k].hold;
        m[k].lsb  = m[k].lsb ^ issue;
        if (stall_clr) m[k].stall = 0;
        else if (sup && m[k].stall < m[k].smax) m[k].stall = m[k].stall + 1;
        if (m[k].pend && wrap) begin
            m[k].spd  = req;
            m[k].pend = 0;
        end else begin
            m[k].pend = (req != m[k].spd);
        end
        m[k].pc = (m[k].pc + 1) % (1 << (m[k].n - 1));
    endtask

    task automatic compare_all();
        check("a_en",    32'(a_en),    32'(m[0].en));
        check("a_en_n",  32'(a_en_n),  32'(m[0].en_n));
        check("a_lsb",   32'(a_lsb),   32'(m[0].lsb));
        check("a_spd",   32'(a_spd),   32'(m[0].spd));
        check("a_pend",  32'(a_pend),  32'(m[0].pend));
        check("a_stall", 32'(a_stall), 32'(m[0].stall));
        check("b_en",    32'(b_en),    32'(m[1].en));
        check("b_en_n",  32'(b_en_n),  32'(m[1].en_n));
        check("b_lsb",   32'(b_lsb),   32'(m[1].lsb));
        check("b_spd",   32'(b_spd),   32'(m[1].spd));
        check("b_pend",  32'(b_pend),  32'(m[1].pend));
        check("b_stall", 32'(b_stall), 32'(m[1].stall));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_en"},    32'(a_en),    0);
        check({tag, "_a_en_n"},  32'(a_en_n),  0);
        check({tag, "_a_lsb"},   32'(a_lsb),   0);
        check({tag, "_a_spd"},   32'(a_spd),   0);
        check({tag, "_a_pend"},  32'(a_pend),  0);
        check({tag, "_a_stall"}, 32'(a_stall), 0);
        check({tag, "_b_en"},    32'(b_en),    0);
        check({tag, "_b_stall"}, 32'(b_stall), 0);
    endtask

    // One cycle: model consumes current inputs, DUT clocks, outputs compared.
    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk_28);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align_a(input int phase);
        for (int i = 0; i < 16 && m[0].pc != phase; i++) step();
    endtask

    initial begin
        m[0].n = 4; m[0].mask = 1; m[0].smax = 65535;
        m[1].n = 3; m[1].mask = 3; m[1].smax = 3;
        model_reset();

        #2;
        check_reset_state("por");
        @(posedge clk_28);
        #1;
        reset_n = 1'b1;

        // Slowest speed idle, then fastest.
        run(24);
        cpu_speed = 2'd3;
        run(20);

        // Switch 0 -> 2 requested mid-period.
        cpu_speed = 2'd0;
        run(12);
        align_a(3);
        cpu_speed = 2'd2;
        run(12);

        // Single-cycle contention on a rise slot at speed 0.
        cpu_speed = 2'd0;
        run(12);
        align_a(0);
        cpu_contend = 1'b1;
        step();
        cpu_contend = 1'b0;
        run(20);

        // Same contention at speed 3: masked off in dut_a.
        cpu_speed = 2'd3;
        run(10);
        cpu_contend = 1'b1;
        step();
        cpu_contend = 1'b0;
        run(4);

        // External wait for 5 cycles at speed 2.
        cpu_speed = 2'd2;
        run(10);
        cpu_wait_n = 1'b0;
        run(5);
        cpu_wait_n = 1'b1;
        run(8);

        // Drive many suppressions to saturate the 2-bit counter, then clear mid-suppression.
        cpu_wait_n = 1'b0;
        run(12);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        run(6);
        cpu_wait_n = 1'b1;
        run(4);

        // Reset asserted while hold is set at speed 0.
        cpu_speed = 2'd0;
        run(12);
        align_a(0);
        cpu_contend = 1'b1;
        step();
        cpu_contend = 1'b0;
        run(2);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("mid");
        @(posedge clk_28);
        #1;
        check_reset_state("held");
        reset_n = 1'b1;
        run(24);

        // Randomized traffic, including clamped out-of-range requests on dut_b.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) cpu_speed = 2'($urandom_range(0, 3));
            cpu_contend = ($urandom_range(0, 3) == 0);
            cpu_wait_n  = ($urandom_range(0, 7) != 0);
            stall_clr   = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
